// File: rtl/beta_rd_seq.sv
// Read-side sequencer for the beta partial-sum RAM of the SCAN polar decoder.
// Takes one node-read request, issues the layer-dependent burst of RAM reads,
// captures the registered RAM data and streams it out through a 2-beat FIFO.
module beta_rd_seq #(
   parameter int P  = 64,
   parameter int Q  = 6,
   parameter int FD = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [4:0]     req_layer,
   input  logic [8:0]     req_addr,
   output logic           err_layer,
   output logic           r_en,
   output logic [4:0]     layer_r,
   output logic [8:0]     r_address,
   output logic [5:0]     cntb,
   input  logic [P*Q-1:0] b_out,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P*Q-1:0] out_data,
   output logic [1:0]     out_beat,
   output logic           out_last
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t           state, nstate;
   logic             alive;
   logic [4:0]       lat_layer;
   logic [8:0]       lat_addr;
   logic [1:0]       beat_cnt;
   logic             inflight;
   logic [1:0]       tag_beat;
   logic             tag_last;
   logic [P*Q-1:0]   mem_data [2];
   logic [1:0]       mem_beat [2];
   logic             mem_last [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       fifo_count;
   logic [2:0]       occ;
   logic             accept, layer_ok, pop, push, issue, last_issue;

   // index of the final beat of a burst for a given layer
   function automatic logic [1:0] last_idx(input logic [4:0] l);
      case (l)
         5'd8:    return 2'd3;
         5'd7:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   assign layer_ok   = (req_layer >= 5'd1) && (req_layer <= 5'd8);
   assign accept     = req_valid && req_ready;
   assign pop        = out_valid && out_ready;
   assign push       = inflight;
   // credit counts beats already in flight so the FIFO can never overflow
   assign occ        = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
   assign last_issue = (beat_cnt == last_idx(lat_layer));

   assign layer_r   = lat_layer;
   assign r_address = lat_addr;
   assign out_valid = (fifo_count != 2'd0);
   assign out_data  = mem_data[rd_ptr];
   assign out_beat  = mem_beat[rd_ptr];
   assign out_last  = mem_last[rd_ptr];

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   // next-state logic
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (accept && layer_ok) nstate = ISSUE;
         ISSUE:   if (issue && last_issue) nstate = DRAIN;
         DRAIN:   if (!inflight && (fifo_count == 2'd0)) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // state-decoded outputs: request handshake and RAM read command
   always_comb begin
      req_ready = (state == IDLE) && alive;
      issue     = (state == ISSUE) && (occ < 3'(FD));
      r_en      = issue;
      cntb      = issue ? {4'b0, beat_cnt} : '0;
   end

   // request latch, beat counter, error pulse and capture tag pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alive     <= 1'b0;
         err_layer <= 1'b0;
         lat_layer <= '0;
         lat_addr  <= '0;
         beat_cnt  <= '0;
         inflight  <= 1'b0;
         tag_beat  <= '0;
         tag_last  <= 1'b0;
      end else begin
         alive     <= 1'b1;
         err_layer <= accept && !layer_ok;
         inflight  <= issue;
         if (accept && layer_ok) begin
            lat_layer <= req_layer;
            lat_addr  <= req_addr;
            beat_cnt  <= '0;
         end else if (issue) begin
            beat_cnt <= beat_cnt + 2'd1;
         end
         if (issue) begin
            tag_beat <= beat_cnt;
            tag_last <= last_issue;
         end
      end
   end

   // two-entry output FIFO; push and pop may coincide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_data[i] <= '0;
            mem_beat[i] <= '0;
            mem_last[i] <= 1'b0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= b_out;
            mem_beat[wr_ptr] <= tag_beat;
            mem_last[wr_ptr] <= tag_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (push && !pop)      fifo_count <= fifo_count + 2'd1;
         else if (pop && !push) fifo_count <= fifo_count - 2'd1;
      end
   end

endmodule

// File: tb/tb_beta_rd_seq.sv
// Self-checking bench for beta_rd_seq: RAM model, queue-based reference of
// expected commands and beats, directed scenarios plus randomized requests.
module tb_beta_rd_seq;
   localparam int P = 64;
   localparam int Q = 6;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [4:0]     req_layer = '0;
   logic [8:0]     req_addr = '0;
   logic           err_layer;
   logic           r_en;
   logic [4:0]     layer_r;
   logic [8:0]     r_address;
   logic [5:0]     cntb;
   logic [P*Q-1:0] b_out = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [P*Q-1:0] out_data;
   logic [1:0]     out_beat;
   logic           out_last;

   beta_rd_seq #(.P(P), .Q(Q), .FD(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_layer(req_layer), .req_addr(req_addr), .err_layer(err_layer),
      .r_en(r_en), .layer_r(layer_r), .r_address(r_address), .cntb(cntb),
      .b_out(b_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_beat(out_beat), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [P*Q-1:0] d;
      logic [1:0]     b;
      logic           l;
   } beat_t;

   beat_t       exp_q[$];
   logic [19:0] cmd_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int issued = 0, popped = 0, err_cnt = 0, ren_cnt = 0;
   logic err_due = 1'b0;
   logic [P*Q-1:0] last_pop = '0;
   int rdy_mode = 1;   // 0: held low, 1: held high, 2: toggle, 3: random
   logic tog = 1'b0;

   task automatic chk(input string tag, input logic [P*Q-1:0] got, input logic [P*Q-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nb_of(input logic [4:0] l);
      if (l == 5'd8) return 4;
      if (l == 5'd7) return 2;
      if (l >= 5'd1 && l <= 5'd6) return 1;
      return 0;
   endfunction

   // RAM contents: hashed per (layer, addr, beat); layers 1..4 hold 2^layer values
   function automatic logic [P*Q-1:0] ram_word(input logic [4:0] l, input logic [8:0] a, input logic [5:0] b);
      logic [P*Q-1:0] w;
      logic [P*Q-1:0] m;
      logic [31:0]    h;
      for (int i = 0; i < (P*Q)/32; i++) begin
         h = {5'd0, l, a, b, 7'(i)};
         h = h * 32'h9E3779B1;
         h = h ^ (h >> 15);
         h = h * 32'h85EBCA6B;
         h = h ^ (h >> 13);
         w[i*32 +: 32] = h;
      end
      if (l >= 5'd1 && l <= 5'd4) begin
         m = '1;
         m = m >> (P*Q - (1 << l) * Q);
         w = w & m;
      end
      return w;
   endfunction

   // RAM: registered read data, one cycle after r_en is sampled
   always @(posedge clk) if (r_en) b_out <= ram_word(layer_r, r_address, cntb);

   // consumer ready pattern
   initial forever begin
      @(posedge clk); #1;
      tog = ~tog;
      case (rdy_mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         2: out_ready = tog;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // monitor: commands, beats, credit bound and error pulses against the model
   always @(negedge clk) begin
      if (rst) begin
         chk("err_layer", 384'(err_layer), 384'(err_due));
         if (err_layer) err_cnt++;
         chk("credit", 384'((issued - popped + int'(r_en) - int'(out_valid && out_ready)) <= 2), 384'(1));
         if (r_en) begin
            ren_cnt++;
            if (cmd_q.size() == 0) chk("cmd_extra", 384'(1), 384'(0));
            else chk("cmd", 384'({layer_r, r_address, cntb}), 384'(cmd_q.pop_front()));
         end else begin
            chk("cntb_idle", 384'(cntb), 384'(0));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 384'(1), 384'(0));
            else begin
               chk("beat_data", out_data, exp_q[0].d);
               chk("beat_tag", 384'({out_beat, out_last}), 384'({exp_q[0].b, exp_q[0].l}));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  last_pop = out_data;
               end
            end
         end
         issued += int'(r_en);
         popped += int'(out_valid && out_ready);
         err_due = req_valid && req_ready && (nb_of(req_layer) == 0);
         if (req_valid && req_ready) begin
            for (int b = 0; b < nb_of(req_layer); b++) begin
               cmd_q.push_back({req_layer, req_addr, 6'(b)});
               exp_q.push_back('{ram_word(req_layer, req_addr, 6'(b)), 2'(b), (b == nb_of(req_layer) - 1)});
            end
         end
      end
   end

   task automatic send(input logic [4:0] l, input logic [8:0] a);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_layer = l; req_addr = a;
      do begin
         @(negedge clk); n++;
      end while (!req_ready && n < 100);
      if (!req_ready) chk("accept_timeout", 384'(0), 384'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(req_ready && exp_q.size() == 0 && cmd_q.size() == 0) && n < 300);
      if (!(req_ready && exp_q.size() == 0 && cmd_q.size() == 0)) chk("idle_timeout", 384'(0), 384'(1));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cmd"}, 384'({r_en, layer_r, r_address, cntb}), 384'(0));
      chk({tag, "_out"}, 384'({out_valid, out_beat, out_last, err_layer, req_ready}), 384'(0));
      chk({tag, "_data"}, out_data, '0);
   endtask

   initial begin
      int n, e0, r0;
      // reset state
      #2 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("ready_before_edge", 384'(req_ready), 384'(0));
      @(negedge clk);
      chk("ready_after_reset", 384'(req_ready), 384'(1));

      // layer 8 streaming: latency and throughput
      rdy_mode = 1;
      send(5'd8, 9'd3);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk("l8_ren", 384'(r_en), 384'(k <= 4));
         chk("l8_valid", 384'(out_valid), 384'(k >= 3 && k <= 6));
      end
      wait_idle();

      // layer 7 with the consumer stalled
      rdy_mode = 0;
      send(5'd7, 9'd5);
      repeat (8) @(negedge clk);
      chk("l7_issued", 384'(issued - popped), 384'(2));
      chk("l7_held", 384'(out_valid), 384'(1));
      chk("l7_cmds_done", 384'(cmd_q.size()), 384'(0));
      rdy_mode = 1;
      wait_idle();

      // layer 2: single beat, zero-padded upper bits
      send(5'd2, 9'd100);
      wait_idle();
      chk("l2_upper_zero", 384'(last_pop[P*Q-1:4*Q]), 384'(0));
      chk("l2_ready", 384'(req_ready), 384'(1));

      // invalid layers
      e0 = err_cnt; r0 = ren_cnt;
      send(5'd0, 9'd7);
      repeat (3) @(negedge clk);
      chk("inv_ready", 384'(req_ready), 384'(1));
      send(5'd9, 9'd8);
      repeat (3) @(negedge clk);
      chk("inv_err_count", 384'(err_cnt - e0), 384'(2));
      chk("inv_no_ren", 384'(ren_cnt - r0), 384'(0));
      chk("inv_ready2", 384'(req_ready), 384'(1));

      // layer 8 with toggling consumer
      rdy_mode = 2;
      send(5'd8, 9'd511);
      wait_idle();

      // reset during the third read of a layer-8 burst
      rdy_mode = 1;
      send(5'd8, 9'd42);
      n = 0;
      while (n < 3) begin
         @(negedge clk);
         if (r_en) n++;
      end
      rst = 1'b0;
      #1 check_all_zero("midreset");
      exp_q.delete(); cmd_q.delete();
      issued = 0; popped = 0; err_due = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", 384'(req_ready), 384'(1));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_reset_novalid", 384'(out_valid), 384'(0));
      end

      // randomized requests
      for (int it = 0; it < 40; it++) begin
         rdy_mode = int'($urandom_range(1, 3));
         send(5'($urandom_range(0, 10)), 9'($urandom));
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/beta_rd_seq.md
Name: beta_rd_seq

Overview:
- Read-side sequencer for the partial-sum (beta) storage RAM in the SCAN polar decoder.
- Accepts one node-read request (layer, node address) over a valid/ready handshake.
- Issues the layer-dependent burst of RAM read commands (r_en, layer_r, r_address, cntb) and captures the RAM's registered b_out.
- Delivers the beats on a flow-controlled output stream to the PE array, tagged with beat index and last flag.

Parameters:
- P, 64, number of beta values per RAM read beat.
- Q, 6, bits per beta value.
- FD, 2, output FIFO depth in beats; fixed at 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request.
- req_layer  in  5  layer of the requested node.
- req_addr  in  9  node address within the layer.
- err_layer  out  1  one-cycle pulse: request accepted with an unsupported layer.
- r_en  out  1  RAM read enable.
- layer_r  out  5  RAM read layer.
- r_address  out  9  RAM read node address.
- cntb  out  6  RAM read beat count.
- b_out  in  P*Q  RAM read data; valid one cycle after r_en is sampled.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  P*Q  beta beat.
- out_beat  out  2  beat index within the burst.
- out_last  out  1  final beat of the burst.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - r_en=0, layer_r=0, r_address=0, cntb=0.
  - out_valid=0, out_data=0, out_beat=0, out_last=0.
  - err_layer=0, req_ready=0.
  - FIFO empty, in-flight counter 0, FSM=IDLE.
  - req_ready rises in the first cycle after rst deasserts.
- Beats per burst (NB) by layer:
  - layer 8 -> 4.
  - layer 7 -> 2.
  - layers 1..6 -> 1.
  - layer 0 or >8 is invalid.
- FSM states:
  - IDLE: req_ready=1. On req_valid:
    - Valid layer: latch layer/addr, beat counter=0, go to ISSUE.
    - Invalid layer: pulse err_layer for one cycle, stay in IDLE; no RAM access.
  - ISSUE: req_ready=0. A read is issued in any cycle where fifo_count + inflight - pop < FD, with pop = out_valid & out_ready.
    - An issue cycle drives r_en=1, layer_r=latched layer, r_address=latched addr, cntb=beat counter, then increments the beat counter.
    - After issuing beat NB-1, go to DRAIN.
  - DRAIN: req_ready=0, r_en=0. When inflight=0, FIFO empty and no capture pending, go to IDLE.
- r_en=0 in every cycle that does not issue. layer_r and r_address hold their last value; cntb returns to 0.
- Capture:
  - inflight is set in the cycle after an issue.
  - b_out is written to the FIFO at the next edge, tagged with beat index and last = (index == NB-1).
  - The tags come from a 1-deep pipeline register that travels with r_en.
- Output stream:
  - out_valid/out_data/out_beat/out_last reflect the FIFO head.
  - Data is held stable while out_valid=1 and out_ready=0.
  - A beat pops on out_valid & out_ready.
- Latency: request accepted at edge E0 -> first r_en during the cycle after E0 -> out_valid high after E2, i.e. 2 cycles from acceptance.
- Throughput: with out_ready held 1, one beat per cycle, no bubbles; a 4-beat burst spans 4 consecutive r_en cycles.
- Backpressure:
  - FIFO can never overflow; the credit rule includes in-flight beats.
  - Simultaneous push and pop in the same cycle is legal and keeps fifo_count unchanged.
- Data passthrough: for layers 1..4 the RAM zero-pads the upper bits; the block passes data unmodified and never alters bit ordering.
- New request: the next request is accepted only after returning to IDLE; back-to-back bursts therefore have at least one idle cycle on r_en.
- Reset mid-burst: all state clears immediately. Data returned by the RAM after reset is ignored (inflight=0), and no out_valid is produced.

Test Plan:
- Layer 8, addr 3, out_ready=1 -> 4 consecutive r_en cycles with cntb 0,1,2,3, r_address=3, layer_r=8; out_valid for 4 cycles starting 2 cycles after acceptance; out_beat 0..3; out_last only on beat 3; data equals the RAM model.
- Layer 7, addr 5, out_ready held 0 -> exactly 2 reads issued, then r_en stays 0; FIFO holds 2 beats; releasing out_ready yields beats 0 and 1 in order with unchanged data.
- Layer 2, addr 100, out_ready=1 -> single read with cntb=0; one beat with out_last=1; upper P*Q-4*Q bits are 0; req_ready returns high after DRAIN.
- Layer 0 request, then layer 9 request -> err_layer pulses once per request; r_en never asserted; req_ready stays 1.
- Layer 8 burst with out_ready toggling 1,0,1,0 -> no beat lost or duplicated; inflight+FIFO never exceeds 2; all 4 beats in order.
- Assert rst low during the third r_en cycle of a layer-8 burst -> all outputs 0 immediately; after release, req_ready=1 and no stale out_valid appears.
